bcd_modn_counter: RTL and testbench
===================================

Name: bcd_modn_counter

Overview:
Parametrised successor to the fixed two-digit seconds/minutes counter. It is a cascaded BCD counter of DIGITS decimal digits that wraps at an arbitrary MODULUS, for example 60 for seconds/minutes, 24 for hours or 100 for a plain decimal counter. It adds up/down counting, synchronous clear, BCD parallel load with validity checking, and a registered wrap pulse. Instances chain through co -> en to build clock/timer displays.

Parameters:
DIGITS, 2, number of BCD digits; legal range 1..4.
MODULUS, 60, count range is 0..MODULUS-1; legal range 2..10^DIGITS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  count enable; one step per clk edge while high
up  input  1  direction: 1 = increment, 0 = decrement
clr  input  1  synchronous clear to 0
ld  input  1  synchronous parallel load
ld_val  input  4*DIGITS  load value, packed BCD, digit 0 in [3:0]
cont  output  4*DIGITS  current count, packed BCD, most significant digit in the top nibble
co  output  1  combinational carry/borrow to the next stage
wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap
ld_err  output  1  registered one-cycle pulse, high in the cycle after a rejected load

Behaviour:
- Reset:
  - rst=0 asynchronously forces cont=0, wrap=0, ld_err=0.
  - Release is sampled on clk.
  - Reset mid-count discards all state; there is no pending carry.
- Synchronous priority per edge: clr > ld > en. Lower-priority requests in the same cycle are ignored.
- clr=1: cont<=0; wrap<=0; ld_err<=0.
- ld=1 (clr=0), load is valid only if both hold:
  - every nibble of ld_val is <= 9;
  - the decimal value of ld_val is < MODULUS.
- Valid load: cont<=ld_val; ld_err<=0.
- Invalid load: cont holds; ld_err<=1 for exactly one cycle.
- en=1, up=1 (clr=0, ld=0):
  - If cont == MODULUS-1: cont<=0 and wrap<=1.
  - Otherwise cont increments by 1 in BCD. Digit k rolls 9->0 and carries into digit k+1 in the same cycle.
- en=1, up=0 (clr=0, ld=0):
  - If cont == 0: cont<=MODULUS-1 in BCD and wrap<=1.
  - Otherwise cont decrements by 1 in BCD. Digit k rolls 0->9 and borrows from digit k+1 in the same cycle.
- en=0 (clr=0, ld=0): cont holds.
- wrap:
  - is 0 on every edge that does not wrap;
  - is never high for two consecutive cycles unless two consecutive edges wrap (MODULUS=2 can do this).
- co is combinational, with no register:
  - co = en & ~clr & ~ld & terminal;
  - terminal = (cont==MODULUS-1) when up=1, and (cont==0) when up=0.
  - co is high in the same cycle as the step that wraps. Connecting it to the next stage's en gives zero-latency cascading.
- Terminal constants:
  - MODULUS-1 is converted to BCD at elaboration.
  - Comparisons are made on BCD values, not binary.
- Non-BCD state cannot be reached, because load is checked and reset clears.
- Direction change takes effect on the same edge; there is no pipeline.
- Illegal parameters (DIGITS outside 1..4, MODULUS outside 2..10^DIGITS) cause an elaboration-time error.

Test Plan:
- Defaults (2, 60), rst pulse then en=1, up=1 for 60 cycles:
  - cont steps 0x00..0x59 then 0x00;
  - co=1 only while cont=0x59;
  - wrap=1 in the cycle cont=0x00 after the wrap.
- Defaults, cont=0x00, up=0, en=1:
  - next cont=0x59, co=1 in the 0x00 cycle, wrap=1 after;
  - a further step gives 0x58.
- Defaults, ld=1 with ld_val=0x45 -> cont=0x45, ld_err=0.
- Defaults, invalid loads:
  - ld_val=0x6A -> cont unchanged, ld_err=1 for one cycle;
  - ld_val=0x60 -> same result.
- Defaults, cont=0x59, clr=1, ld=1, en=1 same cycle -> cont=0x00, co=0, wrap=0.
- Chained DIGITS=2/MODULUS=60 into DIGITS=2/MODULUS=24 via co->en, preloaded to 23:59:
  - one en step -> 00:00, with hour-stage co=1 in the same cycle.
  - Separately, drop rst to 0 mid-count between clock edges -> cont=0x00 immediately, with no clk edge.

Source files
------------

// File: rtl/bcd_modn_counter_if.sv
// Bus bundle for one BCD modulo-N counter stage: control inputs, count and
// status outputs. Stages chain by driving the next stage's en from this co.
interface bcd_modn_counter_if #(
  parameter int DIGITS = 2
);
  // en is a level qualifier with no ready: every rising clk with en=1 (and no
  // clr/ld) is exactly one count step, and the counter always accepts it.
  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  ld;
  logic [4*DIGITS-1:0]   ld_val;
  logic [4*DIGITS-1:0]   cont;
  logic                  co;
  logic                  wrap;
  logic                  ld_err;

  modport master (
    output en, up, clr, ld, ld_val,
    input  cont, co, wrap, ld_err
  );

  modport slave (
    input  en, up, clr, ld, ld_val,
    output cont, co, wrap, ld_err
  );
endinterface

// File: rtl/bcd_modn_counter.sv
// Cascadable up/down BCD counter of DIGITS digits wrapping at MODULUS, with
// synchronous clear, checked BCD parallel load and registered wrap pulse.
module bcd_modn_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic               clk,
  input  logic               rst,
  bcd_modn_counter_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam int           MAX_MOD  = pow10(DIGITS);
  localparam logic [W-1:0] TERM_MAX = to_bcd(MODULUS - 1);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_modn_counter: DIGITS=%0d outside 1..4", DIGITS);
  end
  if (MODULUS < 2 || MODULUS > MAX_MOD) begin : g_bad_modulus
    $error("bcd_modn_counter: MODULUS=%0d outside 2..%0d", MODULUS, MAX_MOD);
  end

  logic [W-1:0] cont_q, cont_d;
  logic         wrap_q, wrap_d;
  logic         ld_err_q, ld_err_d;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         ld_digits_ok;
  logic         ld_ok;
  logic         at_max;
  logic         at_zero;
  logic         terminal;
  logic         step;

  // Ripple +1/-1 through the digits; each digit rolls over only when every
  // lower digit has rolled over in the same cycle.
  always_comb begin : incdec
    logic       carry;
    logic       borrow;
    logic [3:0] dig;
    inc_val = cont_q;
    dec_val = cont_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    dig     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = cont_q[4*k +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = dig + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = dig - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // With every nibble a legal digit, packed BCD orders like its decimal value,
  // so the range check is a plain unsigned compare against MODULUS-1.
  always_comb begin : load_check
    ld_digits_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.ld_val[4*k +: 4] > 4'd9) ld_digits_ok = 1'b0;
    end
    ld_ok = ld_digits_ok && (bus.ld_val <= TERM_MAX);
  end

  always_comb begin : terminal_detect
    at_max   = (cont_q == TERM_MAX);
    at_zero  = (cont_q == '0);
    terminal = bus.up ? at_max : at_zero;
    step     = bus.en & ~bus.clr & ~bus.ld;
  end

  always_comb begin : next_state
    cont_d   = cont_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (bus.clr) begin
      cont_d = '0;
    end else if (bus.ld) begin
      if (ld_ok) begin
        cont_d = bus.ld_val;
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (terminal) begin
        cont_d = bus.up ? '0 : TERM_MAX;
        wrap_d = 1'b1;
      end else begin
        cont_d = bus.up ? inc_val : dec_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cont_q   <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      cont_q   <= cont_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  // co is left combinational so a chained stage steps on the very same edge.
  assign bus.co     = step & terminal;
  assign bus.cont   = cont_q;
  assign bus.wrap   = wrap_q;
  assign bus.ld_err = ld_err_q;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Bench for bcd_modn_counter: a seconds stage (60) cascaded into an hours
// stage (24), checked against an integer modulo reference model.
module tb_bcd_modn_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_modn_counter_if #(.DIGITS(2)) if_a ();
  bcd_modn_counter_if #(.DIGITS(2)) if_h ();

  bcd_modn_counter #(.DIGITS(2), .MODULUS(60)) u_sec (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  bcd_modn_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
    .clk (clk),
    .rst (rst),
    .bus (if_h.slave)
  );

  logic       a_en, a_up, a_clr, a_ld;
  logic [7:0] a_ldv;
  logic       h_up, h_clr, h_ld;
  logic [7:0] h_ldv;

  assign if_a.en     = a_en;
  assign if_a.up     = a_up;
  assign if_a.clr    = a_clr;
  assign if_a.ld     = a_ld;
  assign if_a.ld_val = a_ldv;
  assign if_h.en     = if_a.co;
  assign if_h.up     = h_up;
  assign if_h.clr    = h_clr;
  assign if_h.ld     = h_ld;
  assign if_h.ld_val = h_ldv;

  int          n_total = 0;
  int          n_bad   = 0;
  int          va, vh;
  bit          wa_e, ea_e, wh_e, eh_e;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  // Reference model: the count is an integer in 0..m-1, stepped mod m.
  task automatic model_step(input int m, input bit en, input bit up, input bit clr,
                            input bit ld, input logic [15:0] ldv,
                            inout int v, output bit w, output bit e);
    int dec;
    int nib;
    bit ok;
    w = 1'b0;
    e = 1'b0;
    if (clr) begin
      v = 0;
    end else if (ld) begin
      ok  = 1'b1;
      dec = 0;
      for (int k = 1; k >= 0; k--) begin
        nib = int'((ldv >> (4 * k)) & 16'hF);
        if (nib > 9) ok = 1'b0;
        dec = dec * 10 + nib;
      end
      if (ok && dec < m) v = dec;
      else               e = 1'b1;
    end else if (en) begin
      if (up) begin
        w = (v == m - 1);
        v = (v + 1) % m;
      end else begin
        w = (v == 0);
        v = (v + m - 1) % m;
      end
    end
  endtask

  task automatic idle_inputs();
    a_en = 0; a_up = 1; a_clr = 0; a_ld = 0; a_ldv = '0;
    h_up = 1; h_clr = 0; h_ld = 0; h_ldv = '0;
  endtask

  task automatic tick();
    bit          coa, coh;
    logic [15:0] ba, bh, e;
    #1;
    coa = a_en && !a_clr && !a_ld && (a_up ? (va == 59) : (va == 0));
    coh = coa && !h_clr && !h_ld && (h_up ? (vh == 23) : (vh == 0));
    chk("co_a", 16'(if_a.co), 16'(coa));
    chk("co_h", 16'(if_h.co), 16'(coh));
    model_step(60, a_en, a_up, a_clr, a_ld, 16'(a_ldv), va, wa_e, ea_e);
    model_step(24, coa, h_up, h_clr, h_ld, 16'(h_ldv), vh, wh_e, eh_e);
    ba = to_bcd(va);
    bh = to_bcd(vh);
    exp_q.push_back({ba[7:0], bh[7:0]});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("cont_a", 16'(if_a.cont), 16'(e[15:8]));
    chk("cont_h", 16'(if_h.cont), 16'(e[7:0]));
    chk("wrap_a", 16'(if_a.wrap), 16'(wa_e));
    chk("wrap_h", 16'(if_h.wrap), 16'(wh_e));
    chk("ld_err_a", 16'(if_a.ld_err), 16'(ea_e));
    chk("ld_err_h", 16'(if_h.ld_err), 16'(eh_e));
  endtask

  initial begin
    logic [15:0] tmp;
    idle_inputs();
    va = 0; vh = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    chk("rst_cont_a", 16'(if_a.cont), 16'h00);
    chk("rst_cont_h", 16'(if_h.cont), 16'h00);
    chk("rst_wrap_a", 16'(if_a.wrap), 16'h0);
    chk("rst_ld_err_a", 16'(if_a.ld_err), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // full count-up cycle: 00..59 then wrap to 00, hour stage steps once
    a_en = 1; a_up = 1;
    repeat (60) tick();
    chk("up_wrap_cont", 16'(if_a.cont), 16'h00);
    chk("up_wrap_pulse", 16'(if_a.wrap), 16'h1);
    chk("up_wrap_hour", 16'(if_h.cont), 16'h01);

    // count down from 00 wraps to 59, then 58
    a_up = 0;
    tick();
    chk("dn_wrap_cont", 16'(if_a.cont), 16'h59);
    chk("dn_wrap_pulse", 16'(if_a.wrap), 16'h1);
    tick();
    chk("dn_step_cont", 16'(if_a.cont), 16'h58);
    chk("dn_step_nowrap", 16'(if_a.wrap), 16'h0);

    // loads: valid, bad digit, out of range
    idle_inputs();
    a_ld = 1; a_ldv = 8'h45;
    tick();
    chk("ld_ok_cont", 16'(if_a.cont), 16'h45);
    chk("ld_ok_err", 16'(if_a.ld_err), 16'h0);
    a_ldv = 8'h6A;
    tick();
    chk("ld_6a_cont", 16'(if_a.cont), 16'h45);
    chk("ld_6a_err", 16'(if_a.ld_err), 16'h1);
    a_ldv = 8'h60;
    tick();
    chk("ld_60_cont", 16'(if_a.cont), 16'h45);
    chk("ld_60_err", 16'(if_a.ld_err), 16'h1);
    a_ld = 0;
    tick();
    chk("ld_err_clears", 16'(if_a.ld_err), 16'h0);

    // clr beats ld and en at the terminal count
    a_ld = 1; a_ldv = 8'h59;
    tick();
    a_clr = 1; a_ld = 1; a_ldv = 8'h33; a_en = 1; a_up = 1;
    #1 chk("clr_co", 16'(if_a.co), 16'h0);
    tick();
    chk("clr_cont", 16'(if_a.cont), 16'h00);
    chk("clr_wrap", 16'(if_a.wrap), 16'h0);

    // cascade 23:59 -> 00:00 in one step
    idle_inputs();
    a_ld = 1; a_ldv = 8'h59; h_ld = 1; h_ldv = 8'h23;
    tick();
    idle_inputs();
    a_en = 1;
    #1 chk("chain_co_h", 16'(if_h.co), 16'h1);
    tick();
    chk("chain_sec", 16'(if_a.cont), 16'h00);
    chk("chain_hr", 16'(if_h.cont), 16'h00);
    chk("chain_wrap_h", 16'(if_h.wrap), 16'h1);

    // randomized traffic on both stages
    for (int i = 0; i < 1500; i++) begin
      a_clr = ($urandom_range(0, 15) == 0);
      a_ld  = ($urandom_range(0, 7) == 0);
      a_en  = ($urandom_range(0, 3) != 0);
      a_up  = ($urandom_range(0, 2) != 0);
      tmp   = to_bcd($urandom_range(0, 69));
      a_ldv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : tmp[7:0];
      h_clr = ($urandom_range(0, 31) == 0);
      h_ld  = ($urandom_range(0, 15) == 0);
      h_up  = ($urandom_range(0, 1) != 0);
      tmp   = to_bcd($urandom_range(0, 29));
      h_ldv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : tmp[7:0];
      tick();
    end

    // asynchronous reset between edges clears without a clock
    idle_inputs();
    a_ld = 1; a_ldv = 8'h37; h_ld = 1; h_ldv = 8'h12;
    tick();
    idle_inputs();
    a_en = 1;
    tick();
    #3 rst = 1'b0;
    #1;
    chk("async_cont_a", 16'(if_a.cont), 16'h00);
    chk("async_cont_h", 16'(if_h.cont), 16'h00);
    chk("async_wrap_a", 16'(if_a.wrap), 16'h0);
    va = 0; vh = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_cont", 16'(if_a.cont), 16'h03);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
